multdiv_ctrl: RTL and testbench

Sequencer between the processor pipeline and the shared mult/div datapath. Accepts one MULT or DIV request at a time through a valid/ready handshake. Registers and holds the operands, issues the one-cycle ctrl_MULT/ctrl_DIV start pulse, and waits for data_resultRDY. It then returns result, exception and destination tag through a valid/ready response port, and owns the pipeline stall (busy) and the watchdog timeout.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_wait_cnt.sv | 34 +++
 rtl/multdiv_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the mult/div sequencer: op encoding, FSM states,
// default watchdog limit.
package multdiv_pkg;

    localparam logic OP_MULT         = 1'b0;
    localparam logic OP_DIV          = 1'b1;
    localparam int   TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_div_by_zero(input logic op, input logic [31:0] b);
        return (op == OP_DIV) && (b == 32'd0);
    endfunction

endpackage

// File: rtl/multdiv_wait_cnt.sv
// Watchdog counter for the WAIT state: synchronous clear/enable, flags the
// last allowed cycle (cnt == TIMEOUT-1).
module multdiv_wait_cnt
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] cnt,
    output logic       expired
);

    logic [7:0] cnt_r;

    // Cycle counter; clear wins over enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt     = cnt_r;
    assign expired = (cnt_r == 8'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Request/response sequencer in front of the shared mult/div datapath.
// Optional fast divide-by-zero completion: MULTDIV_DIV0_FAST_EN.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              dp_ctrl_MULT,
    output logic              dp_ctrl_DIV,
    output logic [DATA_W-1:0] dp_operandA,
    output logic [DATA_W-1:0] dp_operandB,
    input  logic [DATA_W-1:0] dp_result,
    input  logic              dp_exception,
    input  logic              dp_resultRDY,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_exception,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic              timeout_err
);

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   a_r, b_r, res_r;
    logic [TAG_W-1:0]    tag_r;
    logic                exc_r, tmo_r, ctrl_mult_r, ctrl_div_r, rsp_valid_r, busy_r;
    logic                accept_s, fast_s, cap_s, tmo_s, cnt_clr_s, cnt_en_s;
    logic                ready_s, expired_s;
    logic [7:0]          cnt_s;

    assign ready_s  = (state_r == IDLE) | ((state_r == DONE) & rsp_ready);
    assign accept_s = req_valid & ready_s;

`ifdef MULTDIV_DIV0_FAST_EN
    assign fast_s = accept_s & is_div_by_zero(req_op, 32'(req_b));
`else
    assign fast_s = 1'b0;
`endif

    multdiv_wait_cnt #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .cnt     (cnt_s),
        .expired (expired_s)
    );

    // Next-state and per-state control strobes.
    always_comb begin
        state_s   = state_r;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        cap_s     = 1'b0;
        tmo_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = fast_s ? DONE : START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                cnt_clr_s = 1'b1;
                state_s   = WAIT;
            end
            WAIT: begin
                // cnt == 0 is the first WAIT cycle: a ready still high from the previous op is ignored
                if (dp_resultRDY && (cnt_s != 8'd0)) begin
                    cap_s   = 1'b1;
                    state_s = DONE;
                end else if (expired_s) begin
                    tmo_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    cnt_en_s = 1'b1;
                    state_s  = WAIT;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_s = fast_s ? DONE : START;
                end else if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, operand, response and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            tag_r       <= {TAG_W{1'b0}};
            res_r       <= {DATA_W{1'b0}};
            exc_r       <= 1'b0;
            tmo_r       <= 1'b0;
            ctrl_mult_r <= 1'b0;
            ctrl_div_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                a_r   <= req_a;
                b_r   <= req_b;
                tag_r <= req_tag;
            end else begin
                a_r   <= a_r;
                b_r   <= b_r;
                tag_r <= tag_r;
            end
            if (fast_s || tmo_s) begin
                res_r <= {DATA_W{1'b0}};
                exc_r <= 1'b1;
            end else if (cap_s) begin
                res_r <= dp_result;
                exc_r <= dp_exception;
            end else begin
                res_r <= res_r;
                exc_r <= exc_r;
            end
            tmo_r       <= tmo_r | tmo_s;
            // Pulses are high exactly while the state register holds START
            ctrl_mult_r <= accept_s & ~fast_s & (req_op == OP_MULT);
            ctrl_div_r  <= accept_s & ~fast_s & (req_op == OP_DIV);
            rsp_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign req_ready     = ready_s;
    assign dp_ctrl_MULT  = ctrl_mult_r;
    assign dp_ctrl_DIV   = ctrl_div_r;
    assign dp_operandA   = a_r;
    assign dp_operandB   = b_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_result    = res_r;
    assign rsp_exception = exc_r;
    assign rsp_tag       = tag_r;
    assign busy          = busy_r;
    assign timeout_err   = tmo_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed, table-driven bench for multdiv_ctrl with a behavioural datapath
// that returns results a programmable number of cycles after the start pulse.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

`ifdef MULTDIV_DIV0_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        dp_ctrl_MULT, dp_ctrl_DIV;
    logic [31:0] dp_operandA, dp_operandB, dp_result;
    logic        dp_exception, dp_resultRDY;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_exception;
    logic [4:0]  rsp_tag;
    logic        busy, timeout_err;

    multdiv_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .dp_ctrl_MULT(dp_ctrl_MULT), .dp_ctrl_DIV(dp_ctrl_DIV),
        .dp_operandA(dp_operandA), .dp_operandB(dp_operandB),
        .dp_result(dp_result), .dp_exception(dp_exception), .dp_resultRDY(dp_resultRDY),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_exception(rsp_exception), .rsp_tag(rsp_tag),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // lat = 0 means the datapath never raises ready
    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        int          lat;
        logic [31:0] exp_res;
        logic        exp_exc;
        int          hold;
        bit          stale;
    } vec_t;

    vec_t vecs[8];
    int   n_err = 0;
    int   n_checks = 0;
    bit   exp_tmo = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void dp_model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic e);
        logic signed [63:0] p;
        if (op == OP_MULT) begin
            p = $signed(a) * $signed(b);
            r = p[31:0];
            e = (p != {{32{p[31]}}, p[31:0]});
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
    endfunction

    task automatic start_req(input int i);
        int g = 0;
        req_valid = 1'b0;
        while (!req_ready && g < 50) begin
            tick();
            g++;
        end
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = vecs[i].op;
        req_a     = vecs[i].a;
        req_b     = vecs[i].b;
        req_tag   = vecs[i].tag;
        tick();
        req_valid = 1'b0;
        req_a     = 32'h5A5A_5A5A;
        req_b     = 32'h0000_0000;
        req_tag   = 5'd0;
    endtask

    // Called in the cycle right after accept (k = 1); returns in the first DONE cycle.
    task automatic wait_rsp(input int i);
        int k = 1;
        int n_mult = 0, n_div = 0, bad_pulse = 0, bad_opnd = 0, exp_k;
        bit done = 1'b0, fast;
        logic [31:0] mr;
        logic me;
        fast = FAST && (vecs[i].op == OP_DIV) && (vecs[i].b == 32'd0);
        if (fast) exp_k = 1;
        else if (vecs[i].lat == 0) exp_k = TIMEOUT_DEFAULT + 2;
        else exp_k = vecs[i].lat + 2;
        dp_model(vecs[i].op, vecs[i].a, vecs[i].b, mr, me);
        while (!done && k < 100) begin
            if (vecs[i].stale && (k == 1 || k == 2)) begin
                dp_resultRDY = 1'b1; dp_result = 32'hBAD0_0000; dp_exception = 1'b1;
            end else if (vecs[i].lat != 0 && k == vecs[i].lat + 1) begin
                dp_resultRDY = 1'b1; dp_result = mr; dp_exception = me;
            end else begin
                dp_resultRDY = 1'b0; dp_result = 32'hDEAD_BEEF; dp_exception = 1'b1;
            end
            #1;
            if (dp_ctrl_MULT) n_mult++;
            if (dp_ctrl_DIV) n_div++;
            if ((dp_ctrl_MULT || dp_ctrl_DIV) && (k != 1)) bad_pulse++;
            if (dp_ctrl_MULT && dp_ctrl_DIV) bad_pulse++;
            if (dp_operandA !== vecs[i].a || dp_operandB !== vecs[i].b) bad_opnd++;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                tick();
                k++;
            end
        end
        dp_resultRDY = 1'b0;
        if (vecs[i].lat == 0 && !fast) exp_tmo = 1'b1;
        check($sformatf("rsp_seen[%0d]", i), done, 1'b1);
        check($sformatf("rsp_latency[%0d]", i), k, exp_k);
        check($sformatf("mult_pulses[%0d]", i), n_mult, (!fast && vecs[i].op == OP_MULT) ? 1 : 0);
        check($sformatf("div_pulses[%0d]", i), n_div, (!fast && vecs[i].op == OP_DIV) ? 1 : 0);
        check($sformatf("pulse_shape[%0d]", i), bad_pulse, 0);
        check($sformatf("operand_stable[%0d]", i), bad_opnd, 0);
        check($sformatf("rsp_result[%0d]", i), rsp_result, vecs[i].exp_res);
        check($sformatf("rsp_exception[%0d]", i), rsp_exception, vecs[i].exp_exc);
        check($sformatf("rsp_tag[%0d]", i), rsp_tag, vecs[i].tag);
        check($sformatf("busy_done[%0d]", i), busy, 1'b1);
        check($sformatf("timeout_err[%0d]", i), timeout_err, exp_tmo);
    endtask

    // Stall the response for hold cycles (with junk on the datapath), then accept it.
    task automatic release_rsp(input int i);
        int bad = 0;
        for (int h = 0; h < vecs[i].hold; h++) begin
            rsp_ready = 1'b0;
            dp_resultRDY = 1'b1; dp_result = 32'h1234_5678; dp_exception = ~vecs[i].exp_exc;
            #1;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== vecs[i].exp_res ||
                rsp_exception !== vecs[i].exp_exc || rsp_tag !== vecs[i].tag) bad++;
            tick();
        end
        check($sformatf("rsp_hold[%0d]", i), bad, 0);
        dp_resultRDY = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check($sformatf("req_ready_done[%0d]", i), req_ready, 1'b1);
        tick();
        rsp_ready = 1'b0;
        #1;
        check($sformatf("idle_after[%0d]", i), {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{OP_MULT, 32'd7,          32'd6,       5'd5,  17, 32'd42,       1'b0, 0, 1'b0};
        vecs[1] = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,       5'd12, 9,  32'hFFFF_FFF2, 1'b0, 5, 1'b0};
        vecs[2] = '{OP_DIV,  32'd5,          32'd0,       5'd31, 4,  32'd0,        1'b1, 1, 1'b0};
        vecs[3] = '{OP_MULT, 32'h0001_0000,  32'h0001_0000, 5'd3, 2, 32'd0,        1'b1, 0, 1'b0};
        vecs[4] = '{OP_MULT, 32'd3,          32'd3,       5'd9,  5,  32'd9,        1'b0, 0, 1'b0};
        vecs[5] = '{OP_DIV,  32'd1000,       32'hFFFF_FFF6, 5'd1, 30, 32'hFFFF_FF9C, 1'b0, 2, 1'b1};
        vecs[6] = '{OP_MULT, 32'hFFFF_FFFF,  32'd5,       5'd7,  3,  32'hFFFF_FFFB, 1'b0, 0, 1'b1};
        vecs[7] = '{OP_MULT, 32'd2,          32'd2,       5'd0,  0,  32'd0,        1'b1, 1, 1'b0};

        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = 32'd0; req_b = 32'd0; req_tag = 5'd0;
        dp_result = 32'd0; dp_exception = 1'b0; dp_resultRDY = 1'b0; rsp_ready = 1'b0;
        tick();
        tick();
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_ctrl", {dp_ctrl_MULT, dp_ctrl_DIV, rsp_valid, rsp_exception, busy, timeout_err}, 6'b0);
        check("reset_data", {dp_operandA, dp_operandB}, 64'd0);
        check("reset_rsp", {rsp_result, 27'd0, rsp_tag}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_req(i);
            wait_rsp(i);
            release_rsp(i);
        end

        // Back-to-back: next request accepted on the edge that retires the response
        start_req(3);
        wait_rsp(3);
        req_valid = 1'b1; req_op = vecs[6].op; req_a = vecs[6].a; req_b = vecs[6].b; req_tag = vecs[6].tag;
        rsp_ready = 1'b1;
        #1;
        check("b2b_req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0; req_a = 32'h5A5A_5A5A;
        wait_rsp(6);
        release_rsp(6);

        // Watchdog: datapath never answers
        start_req(7);
        wait_rsp(7);
        release_rsp(7);
        check("timeout_sticky", timeout_err, 1'b1);

        // Reset in the third WAIT cycle
        start_req(4);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_tmo = 1'b0;
        #1;
        check("midreset_state", {req_ready, rsp_valid, busy, dp_ctrl_MULT, dp_ctrl_DIV, timeout_err}, 6'b100000);
        start_req(4);
        wait_rsp(4);
        release_rsp(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
